// File: rtl/nn_train_ctrl.sv
// Training-loop sequencer: per epoch runs hidden forward, output forward (waits on loss),
// then a per-neuron weight write sweep, until the latched epoch count is reached.
module nn_train_ctrl #(
    parameter int HID_N   = 8,
    parameter int FWD_CYC = 2,
    parameter int TMO     = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic [7:0] epochs_i,
    input  logic       loss_valid_i,
    output logic       f0_pass_o,
    output logic       f1_pass_o,
    output logic       b_pass_o,
    output logic       wr_en_o,
    output logic [2:0] wr_idx_o,
    output logic [7:0] epoch_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);

    localparam int CNT_W = 8;
    localparam int TMO_W = (TMO > 1) ? $clog2(TMO) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_F0,
        S_F1,
        S_BP,
        S_CHK,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [7:0]       epochs_q, epochs_d;
    logic [7:0]       epoch_q, epoch_d;
    logic [7:0]       epoch_inc;
    logic             err_q, err_d;

    logic             f0_q, f0_d;
    logic             f1_q, f1_d;
    logic             bp_q, bp_d;
    logic [2:0]       idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    assign epoch_inc = epoch_q + 8'd1;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        tmo_d    = tmo_q;
        epochs_d = epochs_q;
        epoch_d  = epoch_q;
        err_d    = err_q;

        if (en_i) begin
            // abort beats every other transition, including loss/timeout
            if ((state_q != S_IDLE) && abort_i) begin
                state_d = S_IDLE;
                cnt_d   = '0;
                tmo_d   = '0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_i) begin
                            epochs_d = epochs_i;
                            epoch_d  = 8'd0;
                            err_d    = 1'b0;
                            cnt_d    = '0;
                            state_d  = (epochs_i == 8'd0) ? S_DONE : S_F0;
                        end
                    end
                    S_F0: begin
                        if (cnt_q == CNT_W'(FWD_CYC - 1)) begin
                            state_d = S_F1;
                            cnt_d   = '0;
                            tmo_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    S_F1: begin
                        if (loss_valid_i) begin
                            state_d = S_BP;
                            cnt_d   = '0;
                        end else if (tmo_q == TMO_W'(TMO - 1)) begin
                            state_d = S_IDLE;
                            err_d   = 1'b1;
                            tmo_d   = '0;
                        end else begin
                            tmo_d = tmo_q + TMO_W'(1);
                        end
                    end
                    S_BP: begin
                        if (cnt_q == CNT_W'(HID_N - 1)) begin
                            state_d = S_CHK;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    S_CHK: begin
                        epoch_d = epoch_inc;
                        cnt_d   = '0;
                        state_d = (epoch_inc == epochs_q) ? S_DONE : S_F0;
                    end
                    S_DONE: begin
                        state_d = S_IDLE;
                    end
                    default: begin
                        state_d = S_IDLE;
                    end
                endcase
            end
        end
    end

    // Outputs are registered from the next state so they line up with the state register
    always_comb begin
        f0_d   = (state_d == S_F0);
        f1_d   = (state_d == S_F1);
        bp_d   = (state_d == S_BP);
        idx_d  = (state_d == S_BP) ? cnt_d[2:0] : 3'd0;
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            tmo_q    <= '0;
            epochs_q <= 8'd0;
            epoch_q  <= 8'd0;
            err_q    <= 1'b0;
            f0_q     <= 1'b0;
            f1_q     <= 1'b0;
            bp_q     <= 1'b0;
            idx_q    <= 3'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
            epochs_q <= epochs_d;
            epoch_q  <= epoch_d;
            err_q    <= err_d;
            f0_q     <= f0_d;
            f1_q     <= f1_d;
            bp_q     <= bp_d;
            idx_q    <= idx_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign f0_pass_o = f0_q;
    assign f1_pass_o = f1_q;
    assign b_pass_o  = bp_q;
    assign wr_en_o   = bp_q;
    assign wr_idx_o  = idx_q;
    assign epoch_o   = epoch_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign err_o     = err_q;

endmodule
